// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the three master command/response ports and the SDRAM
//   controller command port that the arbiter sits between.
//   Modports:
//     slave  - the arbiter's view: master requests and controller
//              responses come in; acks, read returns and the muxed
//              controller command go out.
//     master - the surrounding system's view (masters plus controller).
//   Per master N (0=VGA, 1=CPU instr, 2=CPU data):
//     mN_req/mN_write/mN_addr/mN_wdata/mN_be  command, held until mN_ack
//     mN_ack                                  one-cycle accept pulse
//     mN_rvalid                               one-cycle read-data pulse
//   Shared: m_rdata (read data for whichever mN_rvalid is high)
//   Controller: sd_req/sd_write/sd_addr/sd_wdata/sd_be command out,
//               sd_ready accept in, sd_rvalid/sd_rdata in-order returns.
interface sdram_arbiter_if #(
    parameter int AW = 26
);
    logic          m0_req;
    logic          m0_write;
    logic [AW-1:0] m0_addr;
    logic [31:0]   m0_wdata;
    logic [3:0]    m0_be;
    logic          m0_ack;
    logic          m0_rvalid;

    logic          m1_req;
    logic          m1_write;
    logic [AW-1:0] m1_addr;
    logic [31:0]   m1_wdata;
    logic [3:0]    m1_be;
    logic          m1_ack;
    logic          m1_rvalid;

    logic          m2_req;
    logic          m2_write;
    logic [AW-1:0] m2_addr;
    logic [31:0]   m2_wdata;
    logic [3:0]    m2_be;
    logic          m2_ack;
    logic          m2_rvalid;

    logic [31:0]   m_rdata;

    logic          sd_req;
    logic          sd_write;
    logic [AW-1:0] sd_addr;
    logic [31:0]   sd_wdata;
    logic [3:0]    sd_be;
    logic          sd_ready;
    logic          sd_rvalid;
    logic [31:0]   sd_rdata;

    modport slave (
        input  m0_req, m0_write, m0_addr, m0_wdata, m0_be,
        input  m1_req, m1_write, m1_addr, m1_wdata, m1_be,
        input  m2_req, m2_write, m2_addr, m2_wdata, m2_be,
        output m0_ack, m0_rvalid, m1_ack, m1_rvalid, m2_ack, m2_rvalid,
        output m_rdata,
        output sd_req, sd_write, sd_addr, sd_wdata, sd_be,
        input  sd_ready, sd_rvalid, sd_rdata
    );

    modport master (
        output m0_req, m0_write, m0_addr, m0_wdata, m0_be,
        output m1_req, m1_write, m1_addr, m1_wdata, m1_be,
        output m2_req, m2_write, m2_addr, m2_wdata, m2_be,
        input  m0_ack, m0_rvalid, m1_ack, m1_rvalid, m2_ack, m2_rvalid,
        input  m_rdata,
        input  sd_req, sd_write, sd_addr, sd_wdata, sd_be,
        output sd_ready, sd_rvalid, sd_rdata
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command port between the VGA scan-out
//   engine (port 0), CPU instruction fetch (port 1) and CPU data (port 2).
//   One single-word command is granted at a time; outstanding reads are
//   tracked in an in-order tag FIFO so returning data is routed back to
//   the master that issued it.
//   Ports:
//     clock    system clock
//     reset_n  asynchronous active-low reset
//     bus      sdram_arbiter_if.slave (masters + controller signals);
//              the interface AW must equal this module's AW
//     err      sticky: read data returned with no read outstanding
//   Parameters:
//     AW        word address width
//     TAG_DEPTH max outstanding reads (power of 2, >= 2)
//     MAX_HOG   max consecutive port-0 grants while port 1/2 waits
module sdram_arbiter #(
    parameter int AW        = 26,
    parameter int TAG_DEPTH = 4,
    parameter int MAX_HOG   = 8
) (
    input  logic           clock,
    input  logic           reset_n,
    sdram_arbiter_if.slave bus,
    output logic           err
);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam int HW = $clog2(MAX_HOG + 1);

    localparam logic [CW-1:0] C_DEPTH   = CW'(TAG_DEPTH);
    localparam logic [HW-1:0] C_HOG_MAX = HW'(MAX_HOG);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_grant, w_grant_nxt;
    logic [HW-1:0] r_hog_cnt, w_hog_nxt;
    logic [1:0]    r_rr_last, w_rr_nxt;

    logic [1:0]    r_tag [TAG_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0]   r_rdata;
    logic [2:0]    r_rvalid;
    logic          r_err;

    logic [2:0]    w_req;
    logic [2:0]    w_write;
    logic [2:0]    w_elig;
    logic          w_other;
    logic          w_fifo_full;

    logic          w_sd_req;
    logic [2:0]    w_ack;
    logic          w_push;
    logic          w_pop;

    logic          w_sel_write;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic [3:0]    w_sel_be;

    assign w_req   = {bus.m2_req,   bus.m1_req,   bus.m0_req};
    assign w_write = {bus.m2_write, bus.m1_write, bus.m0_write};

    // A full tag FIFO only blocks reads; writes need no tag.
    assign w_fifo_full = (r_count == C_DEPTH);
    assign w_elig      = w_req & (w_write | {3{~w_fifo_full}});
    assign w_other     = w_elig[1] | w_elig[2];

    // Command fields of the latched grant.
    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        case (r_grant)
            2'd0: begin
                w_sel_write = bus.m0_write;
                w_sel_addr  = bus.m0_addr;
                w_sel_wdata = bus.m0_wdata;
                w_sel_be    = bus.m0_be;
            end
            2'd1: begin
                w_sel_write = bus.m1_write;
                w_sel_addr  = bus.m1_addr;
                w_sel_wdata = bus.m1_wdata;
                w_sel_be    = bus.m1_be;
            end
            2'd2: begin
                w_sel_write = bus.m2_write;
                w_sel_addr  = bus.m2_addr;
                w_sel_wdata = bus.m2_wdata;
                w_sel_be    = bus.m2_be;
            end
            default: ;
        endcase
    end

    // Arbitration (IDLE) and command issue (ISSUE).
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_hog_nxt   = r_hog_cnt;
        w_rr_nxt    = r_rr_last;
        w_sd_req    = 1'b0;
        w_ack       = '0;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_other) begin
                    w_hog_nxt = '0;
                end
                if (|w_elig) begin
                    w_state_nxt = ISSUE;
                    // Port 0 yields only once it has hogged MAX_HOG grants
                    // in a row while someone else was waiting.
                    if (w_elig[0] && !((r_hog_cnt == C_HOG_MAX) && w_other)) begin
                        w_grant_nxt = 2'd0;
                        if (w_other && (r_hog_cnt != C_HOG_MAX)) begin
                            w_hog_nxt = r_hog_cnt + 1'b1;
                        end
                    end else begin
                        w_hog_nxt = '0;
                        if (w_elig[1] && (!w_elig[2] || (r_rr_last == 2'd2))) begin
                            w_grant_nxt = 2'd1;
                            w_rr_nxt    = 2'd1;
                        end else begin
                            w_grant_nxt = 2'd2;
                            w_rr_nxt    = 2'd2;
                        end
                    end
                end
            end
            ISSUE: begin
                w_sd_req = 1'b1;
                if (bus.sd_ready) begin
                    w_ack       = 3'b001 << r_grant;
                    w_push      = ~w_sel_write;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_pop = bus.sd_rvalid & (r_count != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_hog_cnt <= '0;
            r_rr_last <= 2'd2;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_rdata   <= '0;
            r_rvalid  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_hog_cnt <= w_hog_nxt;
            r_rr_last <= w_rr_nxt;

            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase

            // Read return is re-timed one cycle and steered by the FIFO head.
            r_rvalid <= '0;
            if (w_pop) begin
                r_rdata  <= bus.sd_rdata;
                r_rvalid <= 3'b001 << r_tag[r_rptr];
            end

            if (bus.sd_rvalid && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read below r_count.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_tag[r_wptr] <= r_grant;
        end
    end

    assign bus.m0_ack    = w_ack[0];
    assign bus.m1_ack    = w_ack[1];
    assign bus.m2_ack    = w_ack[2];
    assign bus.m0_rvalid = r_rvalid[0];
    assign bus.m1_rvalid = r_rvalid[1];
    assign bus.m2_rvalid = r_rvalid[2];
    assign bus.m_rdata   = r_rdata;

    // Command fields read as zero whenever no command is offered.
    assign bus.sd_req    = w_sd_req;
    assign bus.sd_write  = w_sd_req & w_sel_write;
    assign bus.sd_addr   = w_sd_req ? w_sel_addr  : '0;
    assign bus.sd_wdata  = w_sd_req ? w_sel_wdata : '0;
    assign bus.sd_be     = w_sd_req ? w_sel_be    : '0;

    assign err = r_err;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter. Expected grants and read returns
// are queued when stimulus is applied and compared by a monitor when the
// DUT pulses an ack or rvalid; each scenario task adds its own checks.
module tb_sdram_arbiter;
    localparam int AW = 26;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic err;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    sdram_arbiter_if #(.AW(AW)) bus ();

    sdram_arbiter #(.AW(AW), .TAG_DEPTH(4), .MAX_HOG(8)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .err    (err)
    );

    logic [2:0]    t_req;
    logic [2:0]    t_write;
    logic [AW-1:0] t_addr  [3];
    logic [31:0]   t_wdata [3];
    logic [3:0]    t_be    [3];
    logic          sd_ready;
    logic          sd_rvalid;
    logic [31:0]   sd_rdata;

    assign bus.m0_req = t_req[0];   assign bus.m0_write = t_write[0];
    assign bus.m0_addr = t_addr[0]; assign bus.m0_wdata = t_wdata[0]; assign bus.m0_be = t_be[0];
    assign bus.m1_req = t_req[1];   assign bus.m1_write = t_write[1];
    assign bus.m1_addr = t_addr[1]; assign bus.m1_wdata = t_wdata[1]; assign bus.m1_be = t_be[1];
    assign bus.m2_req = t_req[2];   assign bus.m2_write = t_write[2];
    assign bus.m2_addr = t_addr[2]; assign bus.m2_wdata = t_wdata[2]; assign bus.m2_be = t_be[2];
    assign bus.sd_ready  = sd_ready;
    assign bus.sd_rvalid = sd_rvalid;
    assign bus.sd_rdata  = sd_rdata;

    wire [2:0] w_ack = {bus.m2_ack, bus.m1_ack, bus.m0_ack};
    wire [2:0] w_rv  = {bus.m2_rvalid, bus.m1_rvalid, bus.m0_rvalid};

    typedef struct {
        int            port;
        logic          write;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } cmd_t;

    typedef struct {
        int          port;
        logic [31:0] data;
    } rd_t;

    cmd_t exp_ack_q[$];
    rd_t  exp_rd_q[$];
    int   ack_times[$];

    function automatic logic [AW-1:0] cmd_addr(input int p, input int k);
        return AW'((p << 12) | k);
    endfunction

    function automatic logic [31:0] cmd_wdata(input int p, input int k);
        return 32'hA000_0000 | 32'(p << 16) | 32'(k);
    endfunction

    function automatic cmd_t mk_cmd(input int p, input logic w, input int k);
        cmd_t c;
        c.port  = p;
        c.write = w;
        c.addr  = cmd_addr(p, k);
        c.wdata = cmd_wdata(p, k);
        return c;
    endfunction

    function automatic rd_t mk_rd(input int p, input logic [31:0] d);
        rd_t r;
        r.port = p;
        r.data = d;
        return r;
    endfunction

    task automatic drive_port(input int p, input logic req, input logic w, input int k);
        t_req[p]   = req;
        t_write[p] = w;
        t_addr[p]  = cmd_addr(p, k);
        t_wdata[p] = cmd_wdata(p, k);
        t_be[p]    = 4'hF;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        t_req     = '0;
        sd_ready  = 1'b0;
        sd_rvalid = 1'b0;
        sd_rdata  = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        exp_ack_q.delete();
        exp_rd_q.delete();
        ack_times.delete();
    endtask

    // Scoreboard side: pops an expectation whenever the DUT produces output.
    task automatic monitor();
        cmd_t e;
        rd_t  r;
        forever begin
            @(negedge clock);
            for (int p = 0; p < 3; p++) begin
                if (w_ack[p]) begin
                    n_tests++;
                    if (exp_ack_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL ack_unexpected: got ack on port %0d, required none", p);
                    end else begin
                        e = exp_ack_q.pop_front();
                        if (e.port != p || !(bus.sd_req && bus.sd_ready) || bus.sd_write !== e.write ||
                            bus.sd_addr !== e.addr || bus.sd_be !== 4'hF ||
                            (e.write && bus.sd_wdata !== e.wdata)) begin
                            n_fail++;
                            $display("FAIL ack_cmd: got port %0d wr %b addr %h wdata %h, required port %0d wr %b addr %h wdata %h",
                                     p, bus.sd_write, bus.sd_addr, bus.sd_wdata, e.port, e.write, e.addr, e.wdata);
                        end
                    end
                end
                if (w_rv[p]) begin
                    n_tests++;
                    if (exp_rd_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL rvalid_unexpected: got rvalid on port %0d data %h, required none", p, bus.m_rdata);
                    end else begin
                        r = exp_rd_q.pop_front();
                        if (r.port != p || bus.m_rdata !== r.data) begin
                            n_fail++;
                            $display("FAIL rdata: got port %0d data %h, required port %0d data %h",
                                     p, bus.m_rdata, r.port, r.data);
                        end
                    end
                end
            end
        end
    endtask

    // Each master issues its commands back to back, advancing after each ack.
    task automatic run_masters(input int n0, input int n1, input int n2,
                               input logic wr0, input logic wr1, input logic wr2, input int budget);
        int   rem[3];
        int   k[3];
        logic wr[3];
        int   c;
        rem[0] = n0; rem[1] = n1; rem[2] = n2;
        wr[0] = wr0; wr[1] = wr1; wr[2] = wr2;
        for (int p = 0; p < 3; p++) begin
            k[p] = 0;
            drive_port(p, rem[p] > 0, wr[p], k[p]);
        end
        c = 0;
        while ((rem[0] + rem[1] + rem[2]) > 0 && c < budget) begin
            @(negedge clock);
            for (int p = 0; p < 3; p++) begin
                if (w_ack[p] && rem[p] > 0) begin
                    rem[p]--;
                    k[p]++;
                    ack_times.push_back(cyc);
                end
            end
            @(posedge clock);
            #1;
            for (int p = 0; p < 3; p++) drive_port(p, rem[p] > 0, wr[p], k[p]);
            c++;
        end
        n_tests++;
        if ((rem[0] + rem[1] + rem[2]) != 0) begin
            n_fail++;
            $display("FAIL run_timeout: got %0d commands left, required 0", rem[0] + rem[1] + rem[2]);
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        sd_ready  = 1'b1;
        sd_rvalid = 1'b1;
        sd_rdata  = 32'h1234_5678;
        for (int p = 0; p < 3; p++) drive_port(p, 1'b1, 1'b1, 7);
        repeat (3) begin
            @(negedge clock);
            n_tests++;
            if (w_ack !== 3'b0 || w_rv !== 3'b0 || bus.m_rdata !== 32'h0 || bus.sd_req !== 1'b0 ||
                bus.sd_write !== 1'b0 || bus.sd_addr !== '0 || bus.sd_wdata !== 32'h0 ||
                bus.sd_be !== 4'h0 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_outputs: got ack %b rv %b sd_req %b addr %h err %b, required all 0",
                         w_ack, w_rv, bus.sd_req, bus.sd_addr, err);
            end
        end
        sd_rvalid = 1'b0;
        t_req     = '0;
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (bus.sd_req !== 1'b0 || bus.sd_addr !== '0 || err !== 1'b0 || w_ack !== 3'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got sd_req %b addr %h err %b, required 0", bus.sd_req, bus.sd_addr, err);
        end
    endtask

    task automatic test_single_read();
        cmd_t c;
        do_reset();
        sd_ready = 1'b1;
        c.port = 2; c.write = 1'b0; c.addr = AW'(12'h123); c.wdata = '0;
        exp_ack_q.push_back(c);
        t_req[2] = 1'b1; t_write[2] = 1'b0; t_addr[2] = AW'(12'h123); t_wdata[2] = '0; t_be[2] = 4'hF;
        @(negedge clock);
        n_tests++;
        if (bus.m2_ack !== 1'b0 || bus.sd_req !== 1'b0) begin
            n_fail++;
            $display("FAIL read_cycle0: got ack %b sd_req %b, required 0 0", bus.m2_ack, bus.sd_req);
        end
        @(negedge clock);
        n_tests++;
        if (bus.m2_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL read_ack_cycle1: got m2_ack %b, required 1", bus.m2_ack);
        end
        @(posedge clock); #1 t_req[2] = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        exp_rd_q.push_back(mk_rd(2, 32'hDEADBEEF));
        sd_rvalid = 1'b1; sd_rdata = 32'hDEADBEEF;
        @(negedge clock);
        n_tests++;
        if (w_rv !== 3'b0) begin
            n_fail++;
            $display("FAIL rvalid_early: got rvalid %b, required 000", w_rv);
        end
        @(posedge clock); #1 sd_rvalid = 1'b0; sd_rdata = '0;
        @(negedge clock);
        n_tests++;
        if (w_rv !== 3'b100 || bus.m_rdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rvalid_latency: got rvalid %b data %h, required 100 deadbeef", w_rv, bus.m_rdata);
        end
        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_ack_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_read_drain: got %0d/%0d pending, required 0/0", exp_ack_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        sd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_ack_q.push_back(mk_cmd(1, 1'b1, i));
            exp_ack_q.push_back(mk_cmd(2, 1'b1, i));
        end
        run_masters(0, 6, 6, 1'b1, 1'b1, 1'b1, 60);
        for (int i = 1; i < ack_times.size(); i++) begin
            n_tests++;
            if (ack_times[i] - ack_times[i-1] != 2) begin
                n_fail++;
                $display("FAIL rr_interval: got %0d cycles between acks, required 2", ack_times[i] - ack_times[i-1]);
            end
        end
        n_tests++;
        if (exp_ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d pending acks, required 0", exp_ack_q.size());
        end
    endtask

    task automatic test_hog();
        int k0;
        int k1;
        do_reset();
        sd_ready = 1'b1;
        k0 = 0;
        k1 = 0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) begin
                exp_ack_q.push_back(mk_cmd(0, 1'b1, k0));
                k0++;
            end
            exp_ack_q.push_back(mk_cmd(1, 1'b1, k1));
            k1++;
        end
        for (int i = 0; i < 2; i++) begin
            exp_ack_q.push_back(mk_cmd(0, 1'b1, k0));
            k0++;
        end
        run_masters(18, 2, 0, 1'b1, 1'b1, 1'b1, 100);
        n_tests++;
        if (exp_ack_q.size() != 0 || ack_times.size() != 20) begin
            n_fail++;
            $display("FAIL hog_drain: got %0d pending, %0d acks, required 0, 20", exp_ack_q.size(), ack_times.size());
        end
    endtask

    task automatic test_fifo_full();
        int c;
        bit got;
        do_reset();
        sd_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_ack_q.push_back(mk_cmd(2, 1'b0, i));
        run_masters(0, 0, 4, 1'b0, 1'b0, 1'b0, 40);
        exp_ack_q.push_back(mk_cmd(1, 1'b1, 0));
        drive_port(1, 1'b1, 1'b1, 0);
        drive_port(2, 1'b1, 1'b0, 4);
        got = 0;
        c = 0;
        while (!got && c < 20) begin
            @(negedge clock);
            if (w_ack[1]) got = 1;
            n_tests++;
            if (w_ack[2]) begin
                n_fail++;
                $display("FAIL full_read_granted: got m2_ack 1, required 0");
            end
            @(posedge clock); #1;
            c++;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL full_write_timeout: got no port-1 ack, required ack");
        end
        drive_port(1, 1'b0, 1'b1, 1);
        repeat (6) begin
            @(negedge clock);
            n_tests++;
            if (w_ack[2]) begin
                n_fail++;
                $display("FAIL full_read_granted_late: got m2_ack 1, required 0");
            end
        end
        @(posedge clock); #1;
        exp_ack_q.push_back(mk_cmd(2, 1'b0, 4));
        exp_rd_q.push_back(mk_rd(2, 32'h5A5A_0001));
        sd_rvalid = 1'b1; sd_rdata = 32'h5A5A_0001;
        @(posedge clock); #1 sd_rvalid = 1'b0; sd_rdata = '0;
        got = 0;
        c = 0;
        while (!got && c < 10) begin
            @(negedge clock);
            if (w_ack[2]) got = 1;
            c++;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL fifth_read_timeout: got no port-2 ack after pop, required ack");
        end
        @(posedge clock); #1 drive_port(2, 1'b0, 1'b0, 5);
        repeat (2) @(negedge clock);
        n_tests++;
        if (exp_ack_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL full_drain: got %0d/%0d pending, required 0/0", exp_ack_q.size(), exp_rd_q.size());
        end
    endtask

    task automatic test_mixed_order();
        int order[4];
        order[0] = 0; order[1] = 2; order[2] = 1; order[3] = 2;
        do_reset();
        sd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_ack_q.push_back(mk_cmd(order[i], 1'b0, 0));
            run_masters(order[i] == 0 ? 1 : 0, order[i] == 1 ? 1 : 0, order[i] == 2 ? 1 : 0,
                        1'b0, 1'b0, 1'b0, 10);
        end
        for (int i = 0; i < 4; i++) begin
            exp_rd_q.push_back(mk_rd(order[i], 32'hD000_0000 + 32'(i)));
            sd_rvalid = 1'b1;
            sd_rdata  = 32'hD000_0000 + 32'(i);
            @(posedge clock); #1;
        end
        sd_rvalid = 1'b0;
        sd_rdata  = '0;
        repeat (3) @(negedge clock);
        n_tests++;
        if (exp_ack_q.size() != 0 || exp_rd_q.size() != 0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL mixed_drain: got %0d/%0d pending err %b, required 0/0 err 0",
                     exp_ack_q.size(), exp_rd_q.size(), err);
        end
    endtask

    task automatic test_ready_stall();
        int  c;
        cmd_t e;
        do_reset();
        sd_ready = 1'b0;
        e = mk_cmd(0, 1'b1, 5);
        drive_port(0, 1'b1, 1'b1, 5);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (bus.sd_req !== 1'b1 && c < 5);
        n_tests++;
        if (bus.sd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_no_req: got sd_req %b, required 1", bus.sd_req);
        end
        repeat (10) begin
            @(negedge clock);
            n_tests++;
            if (bus.sd_req !== 1'b1 || bus.sd_write !== 1'b1 || bus.sd_addr !== e.addr ||
                bus.sd_wdata !== e.wdata || w_ack !== 3'b0) begin
                n_fail++;
                $display("FAIL stall_hold: got req %b addr %h wdata %h ack %b, required 1 %h %h 000",
                         bus.sd_req, bus.sd_addr, bus.sd_wdata, w_ack, e.addr, e.wdata);
            end
        end
        @(posedge clock); #1;
        exp_ack_q.push_back(e);
        sd_ready = 1'b1;
        @(negedge clock);
        n_tests++;
        if (bus.m0_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got m0_ack %b, required 1", bus.m0_ack);
        end
        @(posedge clock); #1 drive_port(0, 1'b0, 1'b1, 6);
        @(negedge clock);
        n_tests++;
        if (bus.sd_req !== 1'b0 || bus.sd_addr !== '0 || bus.sd_wdata !== 32'h0 || exp_ack_q.size() != 0) begin
            n_fail++;
            $display("FAIL idle_fields: got req %b addr %h wdata %h pending %0d, required 0",
                     bus.sd_req, bus.sd_addr, bus.sd_wdata, exp_ack_q.size());
        end
    endtask

    task automatic test_reset_midissue();
        do_reset();
        sd_ready = 1'b1;
        exp_ack_q.push_back(mk_cmd(1, 1'b0, 0));
        exp_ack_q.push_back(mk_cmd(1, 1'b0, 1));
        run_masters(0, 2, 0, 1'b0, 1'b0, 1'b0, 20);
        sd_ready = 1'b0;
        drive_port(0, 1'b1, 1'b1, 3);
        @(negedge clock);
        @(negedge clock);
        n_tests++;
        if (bus.sd_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midissue_req: got sd_req %b, required 1", bus.sd_req);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if (bus.sd_req !== 1'b0 || bus.sd_addr !== '0 || bus.sd_wdata !== 32'h0 || bus.sd_write !== 1'b0 ||
            w_ack !== 3'b0 || w_rv !== 3'b0 || bus.m_rdata !== 32'h0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL midissue_reset_outputs: got req %b addr %h ack %b rv %b err %b, required all 0",
                     bus.sd_req, bus.sd_addr, w_ack, w_rv, err);
        end
        t_req = '0;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before_stray: got %b, required 0", err);
        end
        @(posedge clock); #1 sd_rvalid = 1'b1; sd_rdata = 32'hBAD0_BAD0;
        @(posedge clock); #1 sd_rvalid = 1'b0; sd_rdata = '0;
        repeat (3) begin
            @(negedge clock);
            n_tests++;
            if (w_rv !== 3'b0 || err !== 1'b1) begin
                n_fail++;
                $display("FAIL stray_rvalid: got rv %b err %b, required 000 1", w_rv, err);
            end
        end
        n_tests++;
        if (exp_ack_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL midissue_drain: got %0d/%0d pending, required 0/0", exp_ack_q.size(), exp_rd_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        t_req     = '0;
        t_write   = '0;
        for (int p = 0; p < 3; p++) begin
            t_addr[p]  = '0;
            t_wdata[p] = '0;
            t_be[p]    = '0;
        end
        sd_ready  = 1'b0;
        sd_rvalid = 1'b0;
        sd_rdata  = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_single_read();
        test_round_robin();
        test_hog();
        test_fifo_full();
        test_mixed_order();
        test_ready_stall();
        test_reset_midissue();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter that shares the single SDRAM controller command port between the VGA scan-out engine, the CPU instruction fetch and the CPU data port. It sits between those masters and the SDRAM controller that drives the DRAM_* pins. It grants one single-word command at a time, tracks outstanding reads in an in-order tag FIFO, and routes read data back to the issuing master.

## Interface
Parameters:
- AW, 26, word address width
- TAG_DEPTH, 4, max outstanding reads (power of 2)
- MAX_HOG, 8, max consecutive port-0 grants while port 1/2 waits

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- mN_req  in  1  request, N=0..2 (0=VGA, 1=CPU instr, 2=CPU data); held with fields stable until mN_ack
- mN_write  in  1  1=write, 0=read
- mN_addr  in  AW  word address
- mN_wdata  in  32  write data
- mN_be  in  4  byte enables
- mN_ack  out  1  one-cycle pulse: command accepted by controller
- mN_rvalid  out  1  one-cycle pulse: m_rdata valid for port N
- m_rdata  out  32  read data, shared by all ports
- sd_req  out  1  command valid to controller
- sd_write, sd_addr[AW], sd_wdata[32], sd_be[4]  out  -  muxed command fields
- sd_ready  in  1  controller accepts command this cycle when high with sd_req
- sd_rvalid  in  1  read data returning, in issue order
- sd_rdata  in  32  read data
- err  out  1  sticky: sd_rvalid arrived with tag FIFO empty

## Operation
- FSM states: IDLE, ISSUE.
- IDLE: evaluate eligible ports. A port is eligible when req=1 and (write=1, or tag count < TAG_DEPTH). If any port is eligible, register grant[1:0] and go to ISSUE.
- Priority:
  - Port 0 wins, unless hog_cnt == MAX_HOG and port 1 or 2 is eligible.
  - Otherwise ports 1/2 round-robin. rr_last records the last of 1/2 granted; the other one is preferred. rr_last resets to 2, so port 1 is preferred first.
- hog_cnt:
  - Increments on each port-0 grant while port 1 or 2 is eligible.
  - Clears on any port-1/2 grant, or when neither port 1 nor 2 is eligible.
  - Saturates at MAX_HOG.
- ISSUE:
  - sd_req=1; sd_* fields combinationally muxed from the granted port.
  - When sd_ready=1: mGRANT_ack=1 (combinational, same cycle). If a read, push grant into the tag FIFO. Return to IDLE.
  - Hold ISSUE indefinitely while sd_ready=0.
- Read return:
  - sd_rvalid=1 pops the FIFO head t.
  - m_rdata=sd_rdata (registered).
  - mt_rvalid=1 on the following cycle.
- Tag FIFO:
  - TAG_DEPTH entries x 2 bits; count is log2(TAG_DEPTH)+1 bits.
  - Simultaneous push and pop leaves count unchanged; pointers wrap modulo TAG_DEPTH.
  - Full FIFO blocks read eligibility only; writes still proceed.
- sd_rvalid with count==0: no pop, no rvalid, err set. err is cleared only by reset.
- Reset (any time, including mid-ISSUE or with reads outstanding):
  - All outputs 0, m_rdata 0, err 0.
  - FSM IDLE, FIFO emptied, hog_cnt 0, rr_last=2.
  - In-flight commands are abandoned.

## Timing
- Minimum request-to-ack: req sampled high in IDLE at cycle 0 → sd_req high cycle 1 → ack cycle 1 if sd_ready=1.
- Maximum throughput is one command per 2 cycles, due to the arbitration bubble in IDLE.
- Read data latency through the arbiter: sd_rvalid at cycle k → mN_rvalid/m_rdata at cycle k+1.
- sd_* fields are valid only while sd_req=1; they are 0 when sd_req=0.
- A master deasserting req before ack is a protocol violation; the arbiter still issues the latched grant's current fields.
- Priority is evaluated only in IDLE. A request arriving during ISSUE waits for the next IDLE.

## Test plan
- Single read, port 2, addr 0x123, sd_ready=1 immediately, controller returns 0xDEADBEEF after 3 cycles:
  - m2_ack at cycle 1.
  - m2_rvalid one cycle after sd_rvalid, m_rdata=0xDEADBEEF.
  - m0_rvalid and m1_rvalid never assert.
- Ports 1 and 2 requesting writes continuously, port 0 idle: grants alternate 1,2,1,2, with an ack every 2 cycles.
- Port 0 requesting continuously, port 1 waiting, MAX_HOG=8: grants are eight port-0, then one port-1, then port-0 resumes.
- Tag FIFO full: port 2 issues 4 reads with no return.
  - A 5th port-2 read is not granted.
  - A port-1 write queued at the same time is granted.
  - After one sd_rvalid, the 5th read issues.
- Mixed outstanding reads in order 0,2,1,2 with returns D0..D3: rvalid pulses on ports 0,2,1,2 with matching data.
- sd_ready held low 10 cycles: sd_req and fields remain stable and no ack occurs until sd_ready rises.
- Reset during ISSUE with 2 reads outstanding:
  - All outputs return to 0.
  - A later stray sd_rvalid sets err=1 and produces no rvalid.
